// File: rtl/traffic_phase_ctrl.sv
// Traffic-light phase controller: NS/EW lamps, per-phase countdown with BCD digits,
// night flashing-yellow mode and realignment to the 59-second cycle counter.
module traffic_phase_ctrl #(
    parameter int T_NS_GREEN  = 25,
    parameter int T_NS_YELLOW = 4,
    parameter int T_EW_GREEN  = 26,
    parameter int T_EW_YELLOW = 4
) (
    input  logic       clk_1s,
    input  logic       rst,
    input  logic [6:0] number,
    input  logic       night_mode,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [6:0] remain,
    output logic [3:0] remain_tens,
    output logic [3:0] remain_ones,
    output logic       sync_err
);

    typedef enum logic [2:0] {NS_G, NS_Y, EW_G, EW_Y, FLASH, ALL_RED} state_t;

    localparam logic [6:0] D_NSG = 7'(T_NS_GREEN);
    localparam logic [6:0] D_NSY = 7'(T_NS_YELLOW);
    localparam logic [6:0] D_EWG = 7'(T_EW_GREEN);
    localparam logic [6:0] D_EWY = 7'(T_EW_YELLOW);

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    state_t     state, state_n;
    logic [6:0] remain_n;
    logic       flash, flash_n;
    logic       sync_err_n;
    logic [2:0] ns_n, ew_n;
    logic       aligned;

    // At number == 0 the cycle must be at the very start of NS green.
    assign aligned = (state == NS_G) && (remain == D_NSG);

    always_comb begin
        state_n    = state;
        remain_n   = remain;
        flash_n    = flash;
        sync_err_n = 1'b0;
        if (night_mode) begin
            state_n  = FLASH;
            remain_n = 7'd0;
            flash_n  = (state == FLASH) ? ~flash : 1'b1;
        end else begin
            case (state)
                FLASH: begin
                    state_n  = ALL_RED;
                    remain_n = 7'd0;
                    flash_n  = 1'b0;
                end
                ALL_RED: begin
                    if (number == 7'd0) begin
                        state_n  = NS_G;
                        remain_n = D_NSG - 7'd1;
                    end
                end
                NS_G, NS_Y, EW_G, EW_Y: begin
                    if ((number == 7'd0) && !aligned) begin
                        state_n    = NS_G;
                        remain_n   = D_NSG - 7'd1;
                        sync_err_n = 1'b1;
                    end else if (remain == 7'd1) begin
                        case (state)
                            NS_G:    begin state_n = NS_Y; remain_n = D_NSY; end
                            NS_Y:    begin state_n = EW_G; remain_n = D_EWG; end
                            EW_G:    begin state_n = EW_Y; remain_n = D_EWY; end
                            default: begin state_n = NS_G; remain_n = D_NSG; end
                        endcase
                    end else begin
                        remain_n = remain - 7'd1;
                    end
                end
                default: begin
                    state_n  = NS_G;
                    remain_n = D_NSG;
                end
            endcase
        end
    end

    // Lamps are decoded from the next state so they come straight out of flops.
    always_comb begin
        ns_n = L_RED;
        ew_n = L_RED;
        case (state_n)
            NS_G:    begin ns_n = L_GRN; ew_n = L_RED; end
            NS_Y:    begin ns_n = L_YEL; ew_n = L_RED; end
            EW_G:    begin ns_n = L_RED; ew_n = L_GRN; end
            EW_Y:    begin ns_n = L_RED; ew_n = L_YEL; end
            FLASH:   begin ns_n = {1'b0, flash_n, 1'b0}; ew_n = {1'b0, flash_n, 1'b0}; end
            default: begin ns_n = L_RED; ew_n = L_RED; end
        endcase
    end

    always_ff @(posedge clk_1s or posedge rst) begin
        if (rst) begin
            state    <= NS_G;
            remain   <= D_NSG;
            flash    <= 1'b0;
            sync_err <= 1'b0;
            ns_light <= L_GRN;
            ew_light <= L_RED;
        end else begin
            state    <= state_n;
            remain   <= remain_n;
            flash    <= flash_n;
            sync_err <= sync_err_n;
            ns_light <= ns_n;
            ew_light <= ew_n;
        end
    end

    assign remain_tens = 4'(remain / 7'd10);
    assign remain_ones = 4'(remain % 7'd10);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: expected outputs are queued as each
// edge is driven and popped/compared #1 after that edge.
module tb_traffic_phase_ctrl;

    logic       clk_1s = 1'b0;
    logic       rst;
    logic [6:0] number;
    logic       night_mode;
    logic [2:0] ns_light, ew_light;
    logic [6:0] remain;
    logic [3:0] remain_tens, remain_ones;
    logic       sync_err;

    traffic_phase_ctrl dut (
        .clk_1s      (clk_1s),
        .rst         (rst),
        .number      (number),
        .night_mode  (night_mode),
        .ns_light    (ns_light),
        .ew_light    (ew_light),
        .remain      (remain),
        .remain_tens (remain_tens),
        .remain_ones (remain_ones),
        .sync_err    (sync_err)
    );

    always #5 clk_1s = ~clk_1s;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic [6:0] rem;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic [6:0] num;
        logic       night;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam exp_t RESET_EXP = '{ns: 3'b001, ew: 3'b100, rem: 7'd25, err: 1'b0};

    // Outputs that must follow the edge at which the counter advances to m (0..58).
    function automatic exp_t cycle_exp(input int m);
        exp_t e;
        e.err = 1'b0;
        if (m <= 24) begin
            e.ns = 3'b001; e.ew = 3'b100; e.rem = 7'(25 - m);
        end else if (m <= 28) begin
            e.ns = 3'b010; e.ew = 3'b100; e.rem = 7'(29 - m);
        end else if (m <= 54) begin
            e.ns = 3'b100; e.ew = 3'b001; e.rem = 7'(55 - m);
        end else begin
            e.ns = 3'b100; e.ew = 3'b010; e.rem = 7'(59 - m);
        end
        return e;
    endfunction

    task automatic check(input string tag);
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, no expected value queued", tag);
        end else begin
            e = sb_q.pop_front();
            if (ns_light !== e.ns || ew_light !== e.ew || remain !== e.rem ||
                remain_tens !== 4'(e.rem / 7'd10) || remain_ones !== 4'(e.rem % 7'd10) ||
                sync_err !== e.err) begin
                n_bad++;
                $display("FAIL %s @%0t: got ns=%b ew=%b remain=%0d tens=%0d ones=%0d sync_err=%b, want ns=%b ew=%b remain=%0d tens=%0d ones=%0d sync_err=%b",
                         tag, $time, ns_light, ew_light, remain, remain_tens, remain_ones, sync_err,
                         e.ns, e.ew, e.rem, e.rem / 7'd10, e.rem % 7'd10, e.err);
            end
        end
    endtask

    task automatic step(input logic [6:0] num, input logic nm, input exp_t e, input string tag);
        number     = num;
        night_mode = nm;
        sb_q.push_back(e);
        @(posedge clk_1s);
        #1;
        check(tag);
    endtask

    vec_t night_tbl[5];

    initial begin
        // Night mode entered in NS_Y, two flash periods, then release while number = 30.
        night_tbl[0] = '{num: 7'd26, night: 1'b1, e: '{3'b010, 3'b010, 7'd0, 1'b0}};
        night_tbl[1] = '{num: 7'd27, night: 1'b1, e: '{3'b000, 3'b000, 7'd0, 1'b0}};
        night_tbl[2] = '{num: 7'd28, night: 1'b1, e: '{3'b010, 3'b010, 7'd0, 1'b0}};
        night_tbl[3] = '{num: 7'd29, night: 1'b1, e: '{3'b000, 3'b000, 7'd0, 1'b0}};
        night_tbl[4] = '{num: 7'd30, night: 1'b0, e: '{3'b100, 3'b100, 7'd0, 1'b0}};

        rst        = 1'b1;
        number     = 7'd0;
        night_mode = 1'b0;
        #2;
        sb_q.push_back(RESET_EXP);
        check("reset");
        rst = 1'b0;

        // Two full cycles with an aligned counter.
        for (int i = 0; i < 120; i++)
            step(7'(i % 59), 1'b0, cycle_exp((i + 1) % 59), "run");

        // Counter restarts at 0 while EW_G has 10 s left.
        for (int n = 2; n <= 44; n++)
            step(7'(n), 1'b0, cycle_exp(n + 1), "pre_resync");
        step(7'd0, 1'b0, '{3'b001, 3'b100, 7'd24, 1'b1}, "resync");
        step(7'd1, 1'b0, cycle_exp(2), "resync_pulse_end");

        for (int n = 2; n <= 25; n++)
            step(7'(n), 1'b0, cycle_exp(n + 1), "to_ns_y");
        for (int i = 0; i < 5; i++)
            step(night_tbl[i].num, night_tbl[i].night, night_tbl[i].e, "night");
        for (int n = 31; n <= 58; n++)
            step(7'(n), 1'b0, '{3'b100, 3'b100, 7'd0, 1'b0}, "all_red_hold");
        step(7'd0, 1'b0, cycle_exp(1), "all_red_exit");

        // Out-of-range number during NS_G.
        for (int n = 1; n <= 4; n++)
            step(7'(n), 1'b0, cycle_exp(n + 1), "pre_oor");
        step(7'd100, 1'b0, cycle_exp(6), "oor_100");
        for (int n = 6; n <= 35; n++)
            step(7'(n), 1'b0, cycle_exp(n + 1), "to_ew_g");

        // Asynchronous reset between edges while in EW_G.
        #2;
        rst = 1'b1;
        #1;
        sb_q.push_back(RESET_EXP);
        check("async_rst");
        #2;
        rst = 1'b0;
        for (int n = 0; n <= 30; n++)
            step(7'(n), 1'b0, cycle_exp(n + 1), "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
